// File: rtl/lock_pkg.sv
// Shared types and constants for the combination-lock sequencing controller.
package lock_pkg;

  // Digit and failure-counter widths used across the lock datapath.
  localparam int DIGIT_W = 4;
  localparam int FAIL_W  = 4;

  // Saturation ceiling of the failed-attempt counter.
  localparam logic [FAIL_W-1:0] FAIL_MAX = '1;

  // Controller states; the encoding is fixed so the status decoder can rely on it.
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CHECK   = 3'd1,
    OPEN    = 3'd2,
    PROGRAM = 3'd3,
    LOCKOUT = 3'd4
  } state_e;

  // Largest of three cycle counts; sizes the shared timer.
  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/cycle_timer.sv
// Loadable down-counter shared by the open window, the alarm lockout and the
// optional idle timeout. Loading N-1 keeps o_expired low for N-1 cycles and
// then holds it high until the next load.
module cycle_timer #(
  parameter int W = 8
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_load,
  input  logic [W-1:0] i_value,
  output logic         o_expired
);

  logic [W-1:0] r_count;

  // Load takes priority; otherwise count down and park at zero.
  always_ff @(posedge i_clk) begin
    // NOTE: sequential state is written with <= only, so every register in the
    // design samples the same pre-edge values regardless of statement order.
    if (!i_rst_n) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_value;
    end else if (r_count != '0) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign o_expired = (r_count == '0);

endmodule

// File: rtl/code_entry_ctrl.sv
// Sequencing controller for the combination lock: collects DIGITS digits, checks
// them against the stored code, and runs the open window, failure counting,
// alarm lockout and code reprogramming. All outputs are registered.
// Optional build macro: AUTO_TIMEOUT_EN (abandon partial entry/programming after
// IDLE_TIMEOUT cycles without an enter).
module code_entry_ctrl
  import lock_pkg::*;
#(
  parameter int DIGITS         = 4,
  parameter int MAX_TRIES      = 3,
  parameter int OPEN_CYCLES    = 1000,
  parameter int LOCKOUT_CYCLES = 5000,
  parameter int IDLE_TIMEOUT   = 2000
) (
  input  logic                       Clock,
  input  logic                       Resetn,
  input  logic                       enter,
  input  logic                       change,
  input  logic [DIGIT_W-1:0]         x,
  output logic                       open,
  output logic                       alarm,
  output logic                       neww,
  output logic [$clog2(DIGITS)-1:0]  digit_idx,
  output logic [FAIL_W-1:0]          fail_cnt
);

  localparam int IDX_W = $clog2(DIGITS);
  localparam int TMR_W = $clog2(max3(OPEN_CYCLES, LOCKOUT_CYCLES, IDLE_TIMEOUT) + 1);

  localparam logic [IDX_W-1:0]  IDX_LAST     = IDX_W'(DIGITS - 1);
  localparam logic [FAIL_W-1:0] TRIES_LIMIT  = FAIL_W'(MAX_TRIES);
  localparam logic [TMR_W-1:0]  OPEN_LOAD    = TMR_W'(OPEN_CYCLES - 1);
  localparam logic [TMR_W-1:0]  LOCKOUT_LOAD = TMR_W'(LOCKOUT_CYCLES - 1);
`ifdef AUTO_TIMEOUT_EN
  localparam logic [TMR_W-1:0]  IDLE_LOAD    = TMR_W'(IDLE_TIMEOUT - 1);
`endif

  // Registered state and outputs.
  state_e                          r_state;
  logic [IDX_W-1:0]                r_idx;
  logic                            r_mismatch;
  logic [FAIL_W-1:0]               r_fail;
  logic                            r_open;
  logic                            r_alarm;
  logic                            r_neww;
  logic [DIGITS-1:0][DIGIT_W-1:0]  r_code;
  logic [DIGITS-1:0][DIGIT_W-1:0]  r_shadow;

  // Next-state values.
  state_e                          w_state_nxt;
  logic [IDX_W-1:0]                w_idx_nxt;
  logic                            w_mismatch_nxt;
  logic [FAIL_W-1:0]               w_fail_nxt;
  logic                            w_open_nxt;
  logic                            w_alarm_nxt;
  logic                            w_neww_nxt;
  logic [DIGITS-1:0][DIGIT_W-1:0]  w_code_nxt;
  logic [DIGITS-1:0][DIGIT_W-1:0]  w_shadow_nxt;

  // Shared timer controls.
  logic                            w_tmr_load;
  logic [TMR_W-1:0]                w_tmr_value;
  logic                            w_tmr_expired;
  logic [FAIL_W-1:0]               w_fail_inc;

  cycle_timer #(
    .W (TMR_W)
  ) u_timer (
    .i_clk     (Clock),
    .i_rst_n   (Resetn),
    .i_load    (w_tmr_load),
    .i_value   (w_tmr_value),
    .o_expired (w_tmr_expired)
  );

  assign w_fail_inc = (r_fail == FAIL_MAX) ? r_fail : r_fail + 1'b1;

  // State and datapath register update; reset abandons any operation in flight.
  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      r_state    <= IDLE;
      r_idx      <= '0;
      r_mismatch <= 1'b0;
      r_fail     <= '0;
      r_open     <= 1'b0;
      r_alarm    <= 1'b0;
      r_neww     <= 1'b0;
      // NOTE: the code store is deliberately reset because a cleared lock must
      // open with all-zero digits; most memories would be left unreset.
      r_code     <= '0;
      r_shadow   <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_idx      <= w_idx_nxt;
      r_mismatch <= w_mismatch_nxt;
      r_fail     <= w_fail_nxt;
      r_open     <= w_open_nxt;
      r_alarm    <= w_alarm_nxt;
      r_neww     <= w_neww_nxt;
      r_code     <= w_code_nxt;
      r_shadow   <= w_shadow_nxt;
    end
  end

  // Next-state, next-output and timer-load decisions for every state.
  always_comb begin
    // NOTE: every signal gets a hold/default value before the case so that no
    // path leaves one unassigned, which would otherwise infer a latch.
    w_state_nxt    = r_state;
    w_idx_nxt      = r_idx;
    w_mismatch_nxt = r_mismatch;
    w_fail_nxt     = r_fail;
    w_open_nxt     = r_open;
    w_alarm_nxt    = r_alarm;
    w_neww_nxt     = r_neww;
    w_code_nxt     = r_code;
    w_shadow_nxt   = r_shadow;
    w_tmr_load     = 1'b0;
    w_tmr_value    = OPEN_LOAD;

    case (r_state)
      IDLE: begin
        if (enter) begin
          w_mismatch_nxt = r_mismatch | (x != r_code[r_idx]);
          if (r_idx == IDX_LAST) begin
            w_idx_nxt   = '0;
            w_state_nxt = CHECK;
          end else begin
            w_idx_nxt = r_idx + 1'b1;
          end
        end
`ifdef AUTO_TIMEOUT_EN
        if (enter) begin
          w_tmr_load  = 1'b1;
          w_tmr_value = IDLE_LOAD;
        end else if (r_idx != '0 && w_tmr_expired) begin
          w_idx_nxt      = '0;
          w_mismatch_nxt = 1'b0;
        end
`endif
      end

      CHECK: begin
        w_mismatch_nxt = 1'b0;
        if (!r_mismatch) begin
          w_state_nxt = OPEN;
          w_open_nxt  = 1'b1;
          w_fail_nxt  = '0;
          w_tmr_load  = 1'b1;
          w_tmr_value = OPEN_LOAD;
        end else begin
          w_fail_nxt = w_fail_inc;
          if (w_fail_inc == TRIES_LIMIT) begin
            w_state_nxt = LOCKOUT;
            w_alarm_nxt = 1'b1;
            w_tmr_load  = 1'b1;
            w_tmr_value = LOCKOUT_LOAD;
          end else begin
            w_state_nxt = IDLE;
          end
        end
      end

      OPEN: begin
        if (change) begin
          w_state_nxt = PROGRAM;
          w_open_nxt  = 1'b0;
          w_neww_nxt  = 1'b1;
          w_idx_nxt   = '0;
`ifdef AUTO_TIMEOUT_EN
          w_tmr_load  = 1'b1;
          w_tmr_value = IDLE_LOAD;
`endif
        end else if (enter || w_tmr_expired) begin
          w_state_nxt = IDLE;
          w_open_nxt  = 1'b0;
        end
      end

      PROGRAM: begin
        if (enter) begin
          w_shadow_nxt[r_idx] = x;
          if (r_idx == IDX_LAST) begin
            // Commit the whole code at once, including the digit arriving now.
            w_code_nxt        = r_shadow;
            w_code_nxt[r_idx] = x;
            w_idx_nxt         = '0;
            w_neww_nxt        = 1'b0;
            w_fail_nxt        = '0;
            w_state_nxt       = IDLE;
          end else begin
            w_idx_nxt = r_idx + 1'b1;
          end
`ifdef AUTO_TIMEOUT_EN
          w_tmr_load  = 1'b1;
          w_tmr_value = IDLE_LOAD;
        end else if (w_tmr_expired) begin
          w_idx_nxt   = '0;
          w_neww_nxt  = 1'b0;
          w_state_nxt = IDLE;
`endif
        end
      end

      LOCKOUT: begin
        w_idx_nxt = '0;
        if (w_tmr_expired) begin
          w_state_nxt = IDLE;
          w_alarm_nxt = 1'b0;
          w_fail_nxt  = '0;
        end
      end

      default: begin
        w_state_nxt    = IDLE;
        w_idx_nxt      = '0;
        w_mismatch_nxt = 1'b0;
        w_open_nxt     = 1'b0;
        w_alarm_nxt    = 1'b0;
        w_neww_nxt     = 1'b0;
      end
    endcase
  end

  assign open      = r_open;
  assign alarm     = r_alarm;
  assign neww      = r_neww;
  assign digit_idx = r_idx;
  assign fail_cnt  = r_fail;

endmodule
